// File: rtl/vibration_meter.sv
// ----------------------------------------------------------------------------
// vibration_meter
// Takes completed STATUS/X/Y/Z frames from the accelerometer SPI master,
// extracts one signed 16-bit axis sample per accepted frame and tracks the
// min/max over a window of 2^WINDOW_LOG2 samples. At window end it reports the
// peak-to-peak amplitude and an 8-LED thermometer level.
//
// Parameters
//   WINDOW_LOG2  : samples per window = 2^WINDOW_LOG2 (1..8)
//   AXIS         : 0 = X, 1 = Y, 2 = Z
//   SHIFT        : right shift applied to p2p before level mapping (0..15)
//   TIMEOUT_LOG2 : stale timeout = 2^TIMEOUT_LOG2 clocks without a frame
//
// Ports
//   sys_clock   in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   frame_ready in   1   SPI master ready level, frame accepted on 0->1
//   frame       in  56   {STATUS, X_L, X_H, Y_L, Y_H, Z_L, Z_H}
//   p2p         out 16   unsigned max-min of the last completed window
//   p2p_valid   out  1   one-cycle pulse when p2p updates
//   level       out  8   thermometer bar, LSB lit first
//   overrun     out  1   sticky, set by an accepted frame with STATUS[7]=1
//   stale       out  1   no frame accepted for the timeout period
// ----------------------------------------------------------------------------
module vibration_meter #(
   parameter int unsigned WINDOW_LOG2  = 5,
   parameter int unsigned AXIS         = 0,
   parameter int unsigned SHIFT        = 8,
   parameter int unsigned TIMEOUT_LOG2 = 22
) (
   input  logic        sys_clock,
   input  logic        reset,
   input  logic        frame_ready,
   input  logic [55:0] frame,
   output logic [15:0] p2p,
   output logic        p2p_valid,
   output logic [7:0]  level,
   output logic        overrun,
   output logic        stale
);

   localparam int unsigned CNT_W   = WINDOW_LOG2 + 1;
   localparam int unsigned WIN_LEN = 32'd1 << WINDOW_LOG2;
   localparam int unsigned TMO_W   = TIMEOUT_LOG2 + 1;
   localparam int unsigned TMO_MAX = 32'd1 << TIMEOUT_LOG2;

   typedef enum logic {
      EMPTY = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Registers
   logic               ready_q;
   logic signed [15:0] sample_q,    sample_d;
   logic               sample_v_q,  sample_v_d;
   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   count_q,     count_d;
   logic signed [15:0] min_q,       min_d;
   logic signed [15:0] max_q,       max_d;
   logic [15:0]        p2p_q,       p2p_d;
   logic               p2p_valid_q, p2p_valid_d;
   logic [7:0]         level_q,     level_d;
   logic               overrun_q,   overrun_d;
   logic               stale_q,     stale_d;
   logic [TMO_W-1:0]   tmo_q,       tmo_d;

   // Combinational helpers
   logic               accept_c;
   logic               sat_c;
   logic signed [15:0] axis_sample_c;
   logic signed [15:0] new_min_c;
   logic signed [15:0] new_max_c;
   logic [CNT_W-1:0]   new_count_c;
   logic [15:0]        diff_c;
   logic               status_unused_c;

   // Thermometer: n = min(8, p >> SHIFT); bit i lit when n > i.
   function automatic logic [7:0] level_map(input logic [15:0] p);
      logic [15:0] shifted;
      logic [7:0]  lvl;
      shifted = p >> SHIFT;
      lvl     = 8'h00;
      for (int i = 0; i < 8; i++) begin
         lvl[i] = (shifted > 16'(i));
      end
      return lvl;
   endfunction

   // Rising edge of the ready level marks a new frame.
   assign accept_c = frame_ready & ~ready_q;

   // Only STATUS[7] is of interest; remaining status bits are ignored.
   assign status_unused_c = ^frame[54:48];

   // Selected axis, bytes arrive low then high.
   always_comb begin
      axis_sample_c = {frame[39:32], frame[47:40]};
      if (AXIS == 1) begin
         axis_sample_c = {frame[23:16], frame[31:24]};
      end else if (AXIS == 2) begin
         axis_sample_c = {frame[7:0], frame[15:8]};
      end
   end

   // Sample capture and sticky overrun.
   always_comb begin
      sample_d   = sample_q;
      sample_v_d = accept_c;
      overrun_d  = overrun_q;
      if (accept_c) begin
         sample_d = axis_sample_c;
         if (frame[55]) begin
            overrun_d = 1'b1;
         end
      end
   end

   // Stale timeout; an accept in the saturating cycle wins.
   always_comb begin
      tmo_d = tmo_q;
      if (accept_c) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_W'(TMO_MAX)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
      sat_c   = ~accept_c & (tmo_d == TMO_W'(TMO_MAX));
      stale_d = sat_c;
   end

   // Window FSM: next state and outputs.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      min_d       = min_q;
      max_d       = max_q;
      p2p_d       = p2p_q;
      p2p_valid_d = 1'b0;
      level_d     = level_q;
      new_min_c   = min_q;
      new_max_c   = max_q;
      new_count_c = count_q;
      diff_c      = 16'h0000;

      if (sample_v_q) begin
         if (state_q == EMPTY) begin
            new_min_c   = sample_q;
            new_max_c   = sample_q;
            new_count_c = CNT_W'(1);
         end else begin
            new_min_c   = (sample_q < min_q) ? sample_q : min_q;
            new_max_c   = (sample_q > max_q) ? sample_q : max_q;
            new_count_c = count_q + CNT_W'(1);
         end

         // max >= min, so the modulo-2^16 difference is the exact span.
         diff_c = unsigned'(new_max_c) - unsigned'(new_min_c);

         if (new_count_c == CNT_W'(WIN_LEN)) begin
            p2p_d       = diff_c;
            p2p_valid_d = 1'b1;
            level_d     = level_map(diff_c);
            count_d     = '0;
            state_d     = EMPTY;
         end else begin
            min_d   = new_min_c;
            max_d   = new_max_c;
            count_d = new_count_c;
            state_d = ACCUM;
         end
      end else if (sat_c) begin
         // No frames for too long: drop the partial window and blank the bar.
         state_d = EMPTY;
         count_d = '0;
         level_d = 8'h00;
      end
   end

   // State register.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         ready_q     <= 1'b1;
         sample_q    <= '0;
         sample_v_q  <= 1'b0;
         state_q     <= EMPTY;
         count_q     <= '0;
         min_q       <= '0;
         max_q       <= '0;
         p2p_q       <= '0;
         p2p_valid_q <= 1'b0;
         level_q     <= '0;
         overrun_q   <= 1'b0;
         stale_q     <= 1'b0;
         tmo_q       <= '0;
      end else begin
         ready_q     <= frame_ready;
         sample_q    <= sample_d;
         sample_v_q  <= sample_v_d;
         state_q     <= state_d;
         count_q     <= count_d;
         min_q       <= min_d;
         max_q       <= max_d;
         p2p_q       <= p2p_d;
         p2p_valid_q <= p2p_valid_d;
         level_q     <= level_d;
         overrun_q   <= overrun_d;
         stale_q     <= stale_d;
         tmo_q       <= tmo_d;
      end
   end

   assign p2p       = p2p_q;
   assign p2p_valid = p2p_valid_q;
   assign level     = level_q;
   assign overrun   = overrun_q;
   assign stale     = stale_q;

endmodule

// File: tb/tb_vibration_meter.sv
// ----------------------------------------------------------------------------
// tb_vibration_meter
// Directed vectors for vibration_meter with 4-sample windows, X axis,
// SHIFT=8 and a 16-clock stale timeout. Expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_vibration_meter;

   logic        sys_clock = 1'b0;
   logic        reset;
   logic        frame_ready;
   logic [55:0] frame;
   logic [15:0] p2p;
   logic        p2p_valid;
   logic [7:0]  level;
   logic        overrun;
   logic        stale;

   int total  = 0;
   int bad    = 0;
   int pulses = 0;
   int base;
   logic v1, v2;

   always #5 sys_clock = ~sys_clock;

   vibration_meter #(
      .WINDOW_LOG2 (2),
      .AXIS        (0),
      .SHIFT       (8),
      .TIMEOUT_LOG2(4)
   ) dut (
      .sys_clock  (sys_clock),
      .reset      (reset),
      .frame_ready(frame_ready),
      .frame      (frame),
      .p2p        (p2p),
      .p2p_valid  (p2p_valid),
      .level      (level),
      .overrun    (overrun),
      .stale      (stale)
   );

   // Count p2p_valid pulses mid-cycle.
   always @(negedge sys_clock) begin
      if (p2p_valid) pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // X carries the sample; Y and Z carry unrelated values.
   function automatic logic [55:0] mk_frame(input logic [7:0] st, input logic [15:0] x);
      logic [15:0] y;
      logic [15:0] z;
      y = ~x;
      z = x ^ 16'h5A5A;
      return {st, x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]};
   endfunction

   // Raise ready for 'hold' cycles (>= 2); v1/v2 capture p2p_valid in k+1/k+2.
   task automatic send(input logic [7:0] st, input logic [15:0] x, input int hold);
      frame       = mk_frame(st, x);
      frame_ready = 1'b1;
      @(posedge sys_clock); #1 v1 = p2p_valid;
      @(posedge sys_clock); #1 v2 = p2p_valid;
      repeat (hold - 2) begin
         @(posedge sys_clock); #1;
      end
      frame_ready = 1'b0;
      frame       = 56'({$urandom, $urandom});
      @(posedge sys_clock); #1;
   endtask

   initial begin
      reset       = 1'b1;
      frame_ready = 1'b1;
      frame       = '0;
      #12;
      check("rst_p2p",     32'(p2p),       32'h0);
      check("rst_valid",   32'(p2p_valid), 32'h0);
      check("rst_level",   32'(level),     32'h0);
      check("rst_overrun", 32'(overrun),   32'h0);
      check("rst_stale",   32'(stale),     32'h0);

      // Ready high through reset release: nothing accepted.
      @(posedge sys_clock); #1 reset = 1'b0;
      repeat (10) begin
         @(posedge sys_clock); #1;
      end
      check("held_pulses", 32'(pulses),      32'd0);
      check("held_count",  32'(dut.count_q), 32'd0);
      frame_ready = 1'b0;
      @(posedge sys_clock); #1;

      // Mixed-sign window: max 0x0100, min -16 -> 272.
      base = pulses;
      send(8'h00, 16'h0010, 2);
      send(8'h00, 16'hFFF0, 2);
      send(8'h00, 16'h0100, 2);
      check("t1_mid_valid", 32'(v2), 32'd0);
      send(8'h00, 16'h0000, 2);
      check("t1_v_k1",   32'(v1),            32'd0);
      check("t1_v_k2",   32'(v2),            32'd1);
      check("t1_p2p",    32'(p2p),           32'd272);
      check("t1_level",  32'(level),         32'h01);
      check("t1_pulses", 32'(pulses - base), 32'd1);

      // Full-scale span.
      send(8'h00, 16'h7FFF, 2);
      send(8'h00, 16'h8000, 2);
      send(8'h00, 16'h8000, 2);
      send(8'h00, 16'h7FFF, 2);
      check("t2_v_k2",  32'(v2),    32'd1);
      check("t2_p2p",   32'(p2p),   32'd65535);
      check("t2_level", 32'(level), 32'hFF);

      // Constant input.
      send(8'h00, 16'h1234, 2);
      send(8'h00, 16'h1234, 2);
      send(8'h00, 16'h1234, 2);
      send(8'h00, 16'h1234, 2);
      check("t3_p2p",   32'(p2p),   32'd0);
      check("t3_level", 32'(level), 32'h00);

      // Long ready pulses: one sample per frame; overrun from STATUS[7].
      check("t4_overrun_pre", 32'(overrun), 32'd0);
      base = pulses;
      send(8'h00, 16'h0000, 10);
      send(8'h80, 16'h0005, 10);
      check("t4_overrun", 32'(overrun), 32'd1);
      send(8'h00, 16'h0300, 10);
      send(8'h00, 16'h0000, 10);
      check("t4_v_k2",   32'(v2),            32'd1);
      check("t4_pulses", 32'(pulses - base), 32'd1);
      check("t4_p2p",    32'(p2p),           32'd768);
      check("t4_level",  32'(level),         32'h07);

      // Frames stop mid-window: stale, level blanked, partial window dropped.
      send(8'h00, 16'h4000, 2);
      send(8'h00, 16'hC000, 2);
      repeat (8) begin
         @(posedge sys_clock); #1;
      end
      check("t5_stale_early", 32'(stale), 32'd0);
      check("t5_level_early", 32'(level), 32'h07);
      repeat (20) begin
         @(posedge sys_clock); #1;
      end
      check("t5_stale",   32'(stale),   32'd1);
      check("t5_level",   32'(level),   32'h00);
      check("t5_p2p_hold", 32'(p2p),    32'd768);
      check("t5_overrun", 32'(overrun), 32'd1);
      base = pulses;
      send(8'h00, 16'h0000, 2);
      check("t5_stale_clr", 32'(stale), 32'd0);
      send(8'h00, 16'h0100, 2);
      send(8'h00, 16'h0000, 2);
      send(8'h00, 16'h0080, 2);
      check("t5_pulses", 32'(pulses - base), 32'd1);
      check("t5_p2p",    32'(p2p),           32'd256);
      check("t5_new_level", 32'(level),      32'h01);

      // Reset mid-window clears everything at once; window restarts.
      send(8'h00, 16'h7000, 2);
      send(8'h00, 16'h9000, 2);
      #2 reset = 1'b1;
      #1;
      check("t6_p2p",     32'(p2p),     32'd0);
      check("t6_level",   32'(level),   32'h00);
      check("t6_overrun", 32'(overrun), 32'd0);
      check("t6_stale",   32'(stale),   32'd0);
      @(posedge sys_clock);
      @(posedge sys_clock); #1 reset = 1'b0;
      @(posedge sys_clock); #1;
      send(8'h00, 16'h0000, 2);
      send(8'h00, 16'h0200, 2);
      send(8'h00, 16'h0000, 2);
      send(8'h00, 16'h0000, 2);
      check("t6_v_k2",      32'(v2),    32'd1);
      check("t6_new_p2p",   32'(p2p),   32'd512);
      check("t6_new_level", 32'(level), 32'h03);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vibration_meter.md
# vibration_meter

Downstream consumer of the accelerometer SPI read path. Takes each completed 56-bit STATUS/X/Y/Z frame from the SPI master, extracts one signed 16-bit axis sample, and tracks min/max over a fixed window of 2^WINDOW_LOG2 samples. At window end it reports peak-to-peak amplitude and an 8-LED thermometer level. It replaces the instantaneous-tilt LED bar with a true vibration-amplitude display.

## Interface
- WINDOW_LOG2, 5: samples per window = 2^WINDOW_LOG2; legal range 1..8.
- AXIS, 0: axis selected (0 = X, 1 = Y, 2 = Z).
- SHIFT, 8: right-shift applied to p2p before mapping to level; legal range 0..15.
- TIMEOUT_LOG2, 22: stale timeout = 2^TIMEOUT_LOG2 clocks without an accepted frame.
- sys_clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- frame_ready  in  1  SPI master ready level; a frame is accepted on its 0->1 transition.
- frame  in  56  {STATUS, X_L, X_H, Y_L, Y_H, Z_L, Z_H}, STATUS in [55:48], Z_H in [7:0].
- p2p  out  16  unsigned max-min of the last completed window.
- p2p_valid  out  1  one-cycle pulse when p2p updates.
- level  out  8  thermometer bar, LSB lit first.
- overrun  out  1  sticky; set by an accepted frame with STATUS[7] = 1.
- stale  out  1  high when no frame has been accepted for the timeout period.

## Operation
- Edge detect: ready_d registers frame_ready; ready_d resets to 1, so a ready already high at reset release is not accepted. accept = frame_ready & ~ready_d.
- Sample extraction: sample = signed {H, L} of the selected axis, e.g. X = {frame[39:32], frame[47:40]}. It is latched into sample_q with sample_v on accept. sample_v clears the following cycle.
- Window FSM, two states:
  - EMPTY: on sample_v, min = max = sample_q; count = 1; go to ACCUM. If WINDOW_LOG2 were 0 this would complete immediately, which is why the legal minimum is 1.
  - ACCUM: on sample_v, min/max are updated with a signed compare; count increments.
  - When the updated count reaches 2^WINDOW_LOG2, on that same edge:
    - p2p = new_max - new_min, 16-bit unsigned, no overflow possible;
    - p2p_valid pulses;
    - level updates;
    - count clears; state goes to EMPTY.
- Level: n = min(8, p2p >> SHIFT); level = (1 << n) - 1. n = 8 gives 8'hFF.
- Overrun: set when STATUS[7] = 1 on an accepted frame; cleared only by reset.
- Timeout counter:
  - clears on accept, otherwise increments, saturating at 2^TIMEOUT_LOG2;
  - at saturation: stale = 1, level = 0, the current window is discarded (EMPTY, count 0), and p2p holds its value;
  - the next accept clears stale and starts a new window.
- Reset values: p2p = 0, p2p_valid = 0, level = 0, overrun = 0, stale = 0, state = EMPTY, count = 0, sample_v = 0, ready_d = 1, timeout = 0.

## Timing
- Let frame_ready go high in cycle k (low in k-1).
  - The sample is registered at the end of k.
  - The window is updated at the end of k+1.
  - If the window completes, p2p, p2p_valid and level are visible in cycle k+2.
  - Latency is 2 clocks.
- Frame bits need to be stable only during cycle k. Later frame changes do not affect the captured sample.
- Accepts are at least 2 cycles apart, because frame_ready must fall between them, so no sample is ever dropped.
- Timeout saturating in the same cycle as an accept: the accept wins, and stale is not asserted.
- Timeout saturation in the same cycle as the window-completing update: the completion is reported (p2p_valid pulses); stale asserts on the next cycle and forces level = 0.
- Reset asserted mid-window: outputs are cleared asynchronously. After release, the window restarts from EMPTY.

## Test plan
- WINDOW_LOG2=2, AXIS=0, SHIFT=8; X samples 0x0010, 0xFFF0, 0x0100, 0x0000 -> p2p = 272, one p2p_valid pulse 2 clocks after the 4th ready edge, level = 8'h01.
- Four samples of 0x7FFF, 0x8000, 0x8000, 0x7FFF -> p2p = 65535, level = 8'hFF. Four samples all equal to 0x1234 -> p2p = 0, level = 8'h00.
- frame_ready held high through reset release and never toggled -> no sample accepted, p2p_valid never pulses, count stays 0.
- frame_ready held high for 10 cycles per frame -> exactly one sample accepted per frame. A frame with STATUS = 0x80 -> overrun = 1 until reset.
- TIMEOUT_LOG2=4 and frames stop mid-window -> stale = 1 and level = 0 after 16 idle clocks. The next 4 frames form a fresh window; the partial window's samples are excluded from p2p.
- Reset pulsed after 2 of 4 samples -> all outputs read 0 immediately. The next 4 samples 0x0000, 0x0200, 0x0000, 0x0000 -> p2p = 512, level = 8'h03.
